grayscale: RTL and testbench
============================

# grayscale

Converts packed 24-bit RGB pixels into 8-bit grayscale pixels for the edge-detect pipeline. Sits directly upstream of the Sobel stage: it pops RGB pixels from the input FIFO and pushes grayscale bytes into the FIFO that feeds `sobel`. It is a two-stage, stall-capable pipeline with frame pixel counting and a frame-done pulse.

## Interface
- `DATA_WIDTH`, 8, grayscale output pixel width.
- `PIXEL_WIDTH`, 24, packed RGB input width: R = [23:16], G = [15:8], B = [7:0].
- `ROW_WIDTH`, 720, pixels per row.
- `NUM_ROWS`, 540, rows per frame.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_rd_en` output 1: pops the input FIFO (first-word-fall-through).
- `in_empty` input 1: input FIFO empty.
- `in_dout` input PIXEL_WIDTH: current head RGB pixel.
- `out_wr_en` output 1: pushes `out_din` into the output FIFO.
- `out_full` input 1: output FIFO full.
- `out_din` output DATA_WIDTH: grayscale pixel.
- `frame_done` output 1: one-cycle pulse on the write of the last pixel of a frame.

## Operation
- Pipeline registers: S1 holds `s1_valid` and the arithmetic intermediate; S2 holds `s2_valid` and the 8-bit result. `out_din` is S2 data.
- `stall = s2_valid & out_full`.
- `in_rd_en = !in_empty & !stall`, combinational. Never asserted while empty.
- When not stalled: S1 <= {in_rd_en, f1(in_dout)}; S2 <= S1. When stalled, S1 and S2 hold their values.
- `out_wr_en = s2_valid & !out_full`.
- Default arithmetic: S1 = R+G+B (10 bits, max 765). S2 = floor(S1/3) (max 255). Any constant-multiply implementation must be exact for every value 0..765.
- Pixel counter: increments on each `out_wr_en`. Width is $clog2(ROW_WIDTH*NUM_ROWS).
  - On the write at count ROW_WIDTH*NUM_ROWS-1: `frame_done` = 1 in that same cycle (combinational from the counter and `out_wr_en`), and the counter wraps to 0.
- No state machine beyond the valid bits and the counter. Frames are back-to-back with no gap required.

## Timing
- Reset values: `in_rd_en`=0 while in reset, `out_wr_en`=0, `out_din`=0, `frame_done`=0, valid bits 0, counter 0.
- Latency: a pixel popped in cycle N is written in cycle N+2 if `out_full` is low in N+2.
- Throughput: one pixel per cycle when the input is never empty and the output is never full.
- Output full: S2 holds and S1 holds. No pop occurs while stalled, so no pixel is lost or duplicated.
- Empty mid-stream: bubbles propagate; `out_wr_en` is low for the corresponding cycles.
- Simultaneous `out_full` deassert and `in_empty` deassert: the write and the pop both occur in the same cycle.
- Reset mid-frame: the pipeline and counter clear immediately (asynchronous). Pixels in flight are discarded. The next written pixel is counted as index 0.

## Configuration
- `GRAYSCALE_WEIGHTED_EN` defined:
  - S1 = 77R + 150G + 29B (16 bits).
  - S2 = S1 >> 8.
  - Latency and handshake are unchanged.
- Not defined: plain average, floor((R+G+B)/3).

## Structure
- Shared package `grayscale_pkg` holds:
  - luma weights (77/150/29) and the shift (8);
  - the divide-by-3 multiplier constants;
  - pipeline depth (2).
- One sub-module: `gray_convert`, a pure combinational function from the RGB components to S1 and from S1 to gray, with the macro selecting between the two modes. The top level holds the registers, handshake and counter.

## Test plan
- Average mode, stream (255,255,255), (0,0,0), (10,20,33) with the FIFOs never empty or full -> outputs 255, 0, 21 on consecutive cycles, first `out_wr_en` 2 cycles after the first pop.
- Weighted mode, (255,0,0), (0,255,0), (0,0,255) -> outputs 76, 149, 28.
- Hold `out_full`=1 for 5 cycles mid-stream -> `in_rd_en` low while S2 is valid, `out_din` held stable, no pixel dropped or duplicated (compare against a reference queue).
- Randomised `in_empty`/`out_full` over 10,000 pixels -> output sequence equals the golden model sequence exactly.
- ROW_WIDTH=4, NUM_ROWS=2, 20 pixels -> `frame_done` pulses on the 8th and 16th writes only.
- Assert `reset` with two pixels in flight -> `out_wr_en` never asserts for them; after release, the next frame's `frame_done` arrives after exactly ROW_WIDTH*NUM_ROWS writes.

Source files
------------

// File: rtl/grayscale_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grayscale_pkg
// Description : Shared constants and types for the RGB-to-grayscale stage.
//               Build option: GRAYSCALE_WEIGHTED_EN selects luma weighting.
// Revision    : 1.0 - initial release
// ============================================================================
package grayscale_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int c_LUMA_R     = 77;
    localparam int c_LUMA_G     = 150;
    localparam int c_LUMA_B     = 29;
    localparam int c_LUMA_SHIFT = 8;

    // floor(x*683 >> 11) equals floor(x/3) for every x in 0..765
    localparam int c_DIV3_MULT  = 683;
    localparam int c_DIV3_SHIFT = 11;

    localparam int c_PIPE_DEPTH = 2;

`ifdef GRAYSCALE_WEIGHTED_EN
    localparam int c_S1_WIDTH = 16;
`else
    localparam int c_S1_WIDTH = 10;
`endif

endpackage
`default_nettype wire

// File: rtl/gray_convert.sv
`default_nettype none
// ============================================================================
// Module      : gray_convert
// Description : Combinational RGB -> intermediate (S1) and S1 -> gray maps.
//               Build option: GRAYSCALE_WEIGHTED_EN (weighted luma vs average).
// Revision    : 1.0 - initial release
// ============================================================================
module gray_convert
    import grayscale_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  rgb_t                  rgb,
    output logic [c_S1_WIDTH-1:0] s1,
    input  logic [c_S1_WIDTH-1:0] s1_in,
    output logic [DATA_WIDTH-1:0] gray
);

`ifdef GRAYSCALE_WEIGHTED_EN
    assign s1   = 16'(rgb.r) * 16'(c_LUMA_R)
                + 16'(rgb.g) * 16'(c_LUMA_G)
                + 16'(rgb.b) * 16'(c_LUMA_B);
    assign gray = DATA_WIDTH'(s1_in >> c_LUMA_SHIFT);
`else
    assign s1   = 10'(rgb.r) + 10'(rgb.g) + 10'(rgb.b);
    assign gray = DATA_WIDTH'((20'(s1_in) * 20'(c_DIV3_MULT)) >> c_DIV3_SHIFT);
`endif

endmodule
`default_nettype wire

// File: rtl/grayscale.sv
`default_nettype none
// ============================================================================
// Module      : grayscale
// Description : Two-stage stall-capable RGB-to-grayscale pipeline with frame
//               pixel counting. Build option: GRAYSCALE_WEIGHTED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module grayscale
    import grayscale_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PIXEL_WIDTH = 24,
    parameter int ROW_WIDTH   = 720,
    parameter int NUM_ROWS    = 540
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   in_rd_en,
    input  logic                   in_empty,
    input  logic [PIXEL_WIDTH-1:0] in_dout,
    output logic                   out_wr_en,
    input  logic                   out_full,
    output logic [DATA_WIDTH-1:0]  out_din,
    output logic                   frame_done
);

    localparam int c_FRAME_PIXELS = ROW_WIDTH * NUM_ROWS;
    localparam int c_CNT_WIDTH    = (c_FRAME_PIXELS > 1) ? $clog2(c_FRAME_PIXELS) : 1;
    localparam logic [c_CNT_WIDTH-1:0] c_LAST_PIXEL = c_CNT_WIDTH'(c_FRAME_PIXELS - 1);

    logic [c_PIPE_DEPTH-1:0] r_valid;
    logic [c_S1_WIDTH-1:0]   r_s1_data;
    logic [DATA_WIDTH-1:0]   r_s2_data;
    logic [c_CNT_WIDTH-1:0]  r_pix_cnt;

    rgb_t                    w_rgb;
    logic [c_S1_WIDTH-1:0]   w_s1;
    logic [DATA_WIDTH-1:0]   w_gray;
    logic                    w_stall;

    assign w_rgb      = rgb_t'(in_dout);
    assign w_stall    = r_valid[c_PIPE_DEPTH-1] & out_full;
    // Gated by reset so no pop is ever issued while the pipeline is cleared
    assign in_rd_en   = !reset & !in_empty & !w_stall;
    assign out_wr_en  = r_valid[c_PIPE_DEPTH-1] & !out_full;
    assign out_din    = r_s2_data;
    assign frame_done = out_wr_en & (r_pix_cnt == c_LAST_PIXEL);

    gray_convert #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_gray_convert (
        .rgb   (w_rgb),
        .s1    (w_s1),
        .s1_in (r_s1_data),
        .gray  (w_gray)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= '0;
            r_s1_data <= '0;
            r_s2_data <= '0;
        end else if (!w_stall) begin
            r_valid   <= {r_valid[c_PIPE_DEPTH-2:0], in_rd_en};
            r_s1_data <= w_s1;
            r_s2_data <= w_gray;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_cnt <= '0;
        end else if (out_wr_en) begin
            r_pix_cnt <= frame_done ? '0 : r_pix_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grayscale.sv
`default_nettype none
// ============================================================================
// Module      : tb_grayscale
// Description : Scoreboard bench for grayscale (small 4x2 frame).
//               Honours GRAYSCALE_WEIGHTED_EN for the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grayscale;

    localparam int RW    = 4;
    localparam int NR    = 2;
    localparam int FRAME = RW * NR;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_rd_en;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        out_wr_en;
    logic        out_full;
    logic [7:0]  out_din;
    logic        frame_done;

    always #5 clk = ~clk;

    grayscale #(
        .DATA_WIDTH  (8),
        .PIXEL_WIDTH (24),
        .ROW_WIDTH   (RW),
        .NUM_ROWS    (NR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .out_din    (out_din),
        .frame_done (frame_done)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int writes = 0;
    int fd_count = 0;
    int first_pop = -1;
    int first_wr = -1;
    int empty_pct = 0;
    int full_pct = 0;
    logic force_full = 1'b0;

    logic [23:0] src_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  out_log[$];
    int          wr_cyc[$];

    function automatic logic [7:0] ref_gray(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
`ifdef GRAYSCALE_WEIGHTED_EN
        return 8'((77 * r + 150 * g + 29 * b) / 256);
`else
        return 8'((r + g + b) / 3);
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    // Input FIFO / output FIFO behaviour, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        if (src_q.size() > 0) in_dout = src_q[0];
        in_empty = (src_q.size() == 0) || ($urandom_range(99) < empty_pct);
        out_full = force_full || ($urandom_range(99) < full_pct);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (out_wr_en) begin
                if (first_wr < 0) first_wr = cyc;
                wr_cyc.push_back(cyc);
                out_log.push_back(out_din);
                if (exp_q.size() == 0) check("unexpected_write", 1, 0);
                else check("out_din", int'(out_din), int'(exp_q.pop_front()));
                check("frame_done", int'(frame_done), int'((writes % FRAME) == FRAME - 1));
                if (frame_done) fd_count++;
                writes++;
            end else if (frame_done) begin
                check("frame_done_idle", 1, 0);
            end
            if (in_rd_en) begin
                if (first_pop < 0) first_pop = cyc;
                if (in_empty) check("rd_while_empty", 1, 0);
                exp_q.push_back(ref_gray(in_dout));
                if (src_q.size() > 0) void'(src_q.pop_front());
                else check("pop_without_data", 1, 0);
            end
        end
    end

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < limit), 1);
    endtask

    initial begin
        logic [7:0] exp_dir[3];
        logic [7:0] held;
        reset    = 1'b1;
        in_empty = 1'b1;
        out_full = 1'b0;
        in_dout  = '0;
`ifdef GRAYSCALE_WEIGHTED_EN
        src_q.push_back(24'hFF0000);
        src_q.push_back(24'h00FF00);
        src_q.push_back(24'h0000FF);
        exp_dir = '{8'd76, 8'd149, 8'd28};
`else
        src_q.push_back({8'd255, 8'd255, 8'd255});
        src_q.push_back({8'd0, 8'd0, 8'd0});
        src_q.push_back({8'd10, 8'd20, 8'd33});
        exp_dir = '{8'd255, 8'd0, 8'd21};
`endif
        repeat (3) @(negedge clk);
        check("reset_rd_en", int'(in_rd_en), 0);
        check("reset_wr_en", int'(out_wr_en), 0);
        check("reset_out_din", int'(out_din), 0);
        check("reset_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Directed stream, no backpressure
        wait_drain("directed_timeout", 50);
        check("directed_count", out_log.size(), 3);
        for (int i = 0; i < 3 && i < out_log.size(); i++)
            check("directed_value", int'(out_log[i]), int'(exp_dir[i]));
        check("latency", first_wr - first_pop, 2);
        if (wr_cyc.size() >= 3) check("throughput", wr_cyc[2] - wr_cyc[0], 2);

        // Output full for 5 cycles with a continuous input stream
        for (int i = 0; i < 12; i++) src_q.push_back(24'($urandom));
        repeat (4) @(negedge clk);
        force_full = 1'b1;
        @(negedge clk);
        held = out_din;
        check("stall_rd_en", int'(in_rd_en), 0);
        check("stall_wr_en", int'(out_wr_en), 0);
        repeat (4) begin
            @(negedge clk);
            check("stall_rd_en", int'(in_rd_en), 0);
            check("stall_hold", int'(out_din), int'(held));
        end
        force_full = 1'b0;
        wait_drain("stall_timeout", 100);

        // Randomised empty/full over 10,000 pixels
        empty_pct = 30;
        full_pct  = 30;
        for (int i = 0; i < 10000; i++) src_q.push_back(24'($urandom));
        wait_drain("random_timeout", 60000);
        empty_pct = 0;
        full_pct  = 0;
        repeat (4) @(negedge clk);

        // Reset with two pixels in flight
        force_full = 1'b1;
        src_q.push_back(24'($urandom));
        src_q.push_back(24'($urandom));
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        src_q.delete();
        writes   = 0;
        fd_count = 0;
        force_full = 1'b0;
        @(negedge clk);
        check("rst_rd_en", int'(in_rd_en), 0);
        check("rst_wr_en", int'(out_wr_en), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_no_write", int'(out_wr_en), 0);
        end
        for (int i = 0; i < 10; i++) src_q.push_back(24'($urandom));
        wait_drain("post_reset_timeout", 100);
        check("post_reset_writes", writes, 10);
        check("post_reset_frames", fd_count, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
